// File: rtl/wrapper_pkg.sv
// Shared constants for the 8bitworkshop game-wrapper front-ends.
// Defaults size the controller and give every wrapper one key numbering.
package wrapper_pkg;

    localparam int DIV_DEF        = 2;
    localparam int N_KEYS_DEF     = 4;
    localparam int DEB_CYCLES_DEF = 16;

    localparam int KEY_LEFT  = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_DOWN  = 3;

endpackage

// File: rtl/wrapper_ctrl_core_key_debounce.sv
// One key: two-flop synchronizer, optional inversion, and a stable-run
// debounce counter that drives a registered active-high level.
module key_debounce
    import wrapper_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter bit KEY_ACT_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic lvl
);

    localparam int                DC_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DC_W-1:0]   DC_LAST = DC_W'(DEB_CYCLES - 1);
    localparam logic              IDLE_RAW = KEY_ACT_LOW;

    logic            s1;
    logic            s2;
    logic            ks;
    logic [DC_W-1:0] dc;

    assign ks = s2 ^ KEY_ACT_LOW;

    // NOTE: non-blocking assignments let s2 take the old s1 and the counter
    // see the old lvl, regardless of statement order inside the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Sync flops park at the raw idle level so ks reads released.
            s1  <= IDLE_RAW;
            s2  <= IDLE_RAW;
            dc  <= '0;
            lvl <= 1'b0;
        end else begin
            s1 <= key;
            s2 <= s1;
            if (ks == lvl) begin
                dc <= '0;
            end else if (dc == DC_LAST) begin
                lvl <= ks;
                dc  <= '0;
            end else begin
                dc <= dc + DC_W'(1);
            end
        end
    end

endmodule

// File: rtl/wrapper_ctrl_core.sv
// Game-wrapper front-end: clock divider with matching enable, and debounced
// keys whose press/release events are held until the next enable.
module wrapper_ctrl_core
    import wrapper_pkg::*;
#(
    parameter int DIV         = DIV_DEF,
    parameter int N_KEYS      = N_KEYS_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter bit KEY_ACT_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys,
    output logic              clk_div,
    output logic              clk_en,
    output logic [N_KEYS-1:0] keys_lvl,
    output logic [N_KEYS-1:0] keys_press,
    output logic [N_KEYS-1:0] keys_rel
);

    localparam int               CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [N_KEYS-1:0] lvl_d;
    logic [N_KEYS-1:0] rise;
    logic [N_KEYS-1:0] fall;
    logic [N_KEYS-1:0] en_mask;
    logic [N_KEYS-1:0] press_pend;
    logic [N_KEYS-1:0] rel_pend;

    // NOTE: every path of a combinational block assigns its outputs, so no
    // latch is inferred; a single ternary covers both cases here.
    always_comb begin
        cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end

    // clk_div is built from cnt_next so it lines up with the registered cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            clk_div <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            clk_div <= (cnt_next >= CNT_HALF);
        end
    end

    assign clk_en = (cnt == CNT_LAST);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .DEB_CYCLES  (DEB_CYCLES),
            .KEY_ACT_LOW (KEY_ACT_LOW)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .key   (keys[i]),
            .lvl   (keys_lvl[i])
        );
    end

    assign en_mask = {N_KEYS{clk_en}};
    assign rise    = keys_lvl & ~lvl_d;
    assign fall    = ~keys_lvl & lvl_d;

    // Set wins over the enable-clear, so a flip during clk_en waits a window.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_d      <= '0;
            press_pend <= '0;
            rel_pend   <= '0;
        end else begin
            lvl_d      <= keys_lvl;
            press_pend <= rise | (press_pend & ~en_mask);
            rel_pend   <= fall | (rel_pend & ~en_mask);
        end
    end

    assign keys_press = press_pend & en_mask;
    assign keys_rel   = rel_pend & en_mask;

endmodule

// File: tb/tb_wrapper_ctrl_core.sv
// Three configurations (DIV=2, DIV=6, active-low DIV=4/DEB=1) checked every
// cycle against a window/event-level model, plus directed scenario checks.
module tb_wrapper_ctrl_core;
    import wrapper_pkg::*;

    localparam int NK = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys_v  [3];
    logic [2:0]    clk_div_v;
    logic [2:0]    clk_en_v;
    logic [NK-1:0] lvl_v   [3];
    logic [NK-1:0] press_v [3];
    logic [NK-1:0] rel_v   [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wrapper_ctrl_core #(.DIV(2), .N_KEYS(NK), .DEB_CYCLES(16), .KEY_ACT_LOW(1'b0)) dut_a (
        .clk(clk), .reset(reset), .keys(keys_v[0]), .clk_div(clk_div_v[0]), .clk_en(clk_en_v[0]),
        .keys_lvl(lvl_v[0]), .keys_press(press_v[0]), .keys_rel(rel_v[0]));
    wrapper_ctrl_core #(.DIV(6), .N_KEYS(NK), .DEB_CYCLES(16), .KEY_ACT_LOW(1'b0)) dut_b (
        .clk(clk), .reset(reset), .keys(keys_v[1]), .clk_div(clk_div_v[1]), .clk_en(clk_en_v[1]),
        .keys_lvl(lvl_v[1]), .keys_press(press_v[1]), .keys_rel(rel_v[1]));
    wrapper_ctrl_core #(.DIV(4), .N_KEYS(NK), .DEB_CYCLES(1), .KEY_ACT_LOW(1'b1)) dut_c (
        .clk(clk), .reset(reset), .keys(keys_v[2]), .clk_div(clk_div_v[2]), .clk_en(clk_en_v[2]),
        .keys_lvl(lvl_v[2]), .keys_press(press_v[2]), .keys_rel(rel_v[2]));

    function automatic int div_of(input int d);
        case (d)
            0:       return 2;
            1:       return 6;
            default: return 4;
        endcase
    endfunction

    function automatic int deb_of(input int d);
        return (d == 2) ? 1 : 16;
    endfunction

    function automatic bit act_of(input int d);
        return (d == 2);
    endfunction

    // Model: phase k since reset, synced-key history, levels, pending events.
    int            k_m   [3];
    int            hcnt  [3];
    logic [NK-1:0] s1m   [3];
    logic [NK-1:0] s2m   [3];
    logic [NK-1:0] lvl_m [3];
    logic [NK-1:0] rise_m[3];
    logic [NK-1:0] fall_m[3];
    logic [NK-1:0] pp_m  [3];
    logic [NK-1:0] rp_m  [3];
    logic [NK-1:0] hist  [3][16];

    int press_cnt[3][NK];
    int rel_cnt  [3][NK];
    int en_cnt   [3];
    int hi_cnt   [3];
    int both_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic rst_i);
        for (int d = 0; d < 3; d++) begin
            if (rst_i) begin
                k_m[d]    = 0;
                hcnt[d]   = 0;
                s1m[d]    = '0;
                s2m[d]    = '0;
                lvl_m[d]  = '0;
                rise_m[d] = '0;
                fall_m[d] = '0;
                pp_m[d]   = '0;
                rp_m[d]   = '0;
            end else begin
                logic [NK-1:0] sample;
                logic [NK-1:0] old;
                bit            en_prev;
                bit            all_flip;
                sample  = s2m[d];
                s2m[d]  = s1m[d];
                s1m[d]  = keys_v[d] ^ {NK{act_of(d)}};
                en_prev = (k_m[d] == div_of(d) - 1);
                pp_m[d] = (en_prev ? '0 : pp_m[d]) | rise_m[d];
                rp_m[d] = (en_prev ? '0 : rp_m[d]) | fall_m[d];
                for (int j = 15; j > 0; j--) hist[d][j] = hist[d][j-1];
                hist[d][0] = sample;
                if (hcnt[d] < 16) hcnt[d]++;
                old = lvl_m[d];
                // A level flips once the last DEB samples all disagree with it.
                if (hcnt[d] >= deb_of(d)) begin
                    for (int b = 0; b < NK; b++) begin
                        all_flip = 1'b1;
                        for (int j = 0; j < deb_of(d); j++)
                            if (hist[d][j][b] == old[b]) all_flip = 1'b0;
                        if (all_flip) lvl_m[d][b] = ~old[b];
                    end
                end
                rise_m[d] = lvl_m[d] & ~old;
                fall_m[d] = ~lvl_m[d] & old;
                k_m[d]    = (k_m[d] + 1) % div_of(d);
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 3; d++) begin
            bit en;
            en = (k_m[d] == div_of(d) - 1);
            check($sformatf("d%0d_clk_div", d), clk_div_v[d], (k_m[d] >= div_of(d) / 2));
            check($sformatf("d%0d_clk_en", d), clk_en_v[d], en);
            check($sformatf("d%0d_lvl", d), lvl_v[d], lvl_m[d]);
            check($sformatf("d%0d_press", d), press_v[d], pp_m[d] & {NK{en}});
            check($sformatf("d%0d_rel", d), rel_v[d], rp_m[d] & {NK{en}});
        end
    endtask

    task automatic clear_tallies();
        for (int d = 0; d < 3; d++) begin
            en_cnt[d] = 0;
            hi_cnt[d] = 0;
            for (int b = 0; b < NK; b++) begin
                press_cnt[d][b] = 0;
                rel_cnt[d][b]   = 0;
            end
        end
        both_cnt = 0;
    endtask

    task automatic tally();
        for (int d = 0; d < 3; d++) begin
            if (clk_en_v[d] === 1'b1) en_cnt[d]++;
            if (clk_div_v[d] === 1'b1) hi_cnt[d]++;
            for (int b = 0; b < NK; b++) begin
                if (press_v[d][b] === 1'b1) press_cnt[d][b]++;
                if (rel_v[d][b] === 1'b1) rel_cnt[d][b]++;
            end
        end
        if (press_v[2][3] === 1'b1 && rel_v[2][3] === 1'b1) both_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step(reset);
        compare_all();
        tally();
    endtask

    initial begin
        int last_en;
        reset     = 1'b1;
        keys_v[0] = '0;
        keys_v[1] = '0;
        keys_v[2] = '1;
        clear_tallies();

        // Reset held three cycles, then DIV=2 toggling.
        repeat (3) tick();
        check("rst_lvl_a", lvl_v[0], 0);
        check("rst_div_a", clk_div_v[0], 0);
        reset = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check("a_div_toggle", clk_div_v[0], t % 2);
            check("a_en_alt", clk_en_v[0], t % 2);
        end

        // DIV=6 ratio over 60 cycles.
        clear_tallies();
        last_en = -1;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (clk_en_v[1] === 1'b1) begin
                if (last_en >= 0) check("b_en_spacing", t - last_en, 6);
                last_en = t;
            end
        end
        check("b_en_count", en_cnt[1], 10);
        check("b_div_high", hi_cnt[1], 30);

        // Debounce latency on key 1.
        clear_tallies();
        keys_v[0][1] = 1'b1;
        keys_v[1][1] = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 17) check("a_lat_before", lvl_v[0][1], 0);
            if (t == 18) check("a_lat_after", lvl_v[0][1], 1);
        end
        check("a_lat_press", press_cnt[0][1], 1);
        check("a_lat_rel", rel_cnt[0][1], 0);
        check("b_lat_press", press_cnt[1][1], 1);

        // Glitch rejection on key 0.
        clear_tallies();
        keys_v[0][0] = 1'b1;
        repeat (10) tick();
        keys_v[0][0] = 1'b0;
        tick();
        keys_v[0][0] = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (t == 17) check("a_glitch_before", lvl_v[0][0], 0);
            if (t == 18) check("a_glitch_after", lvl_v[0][0], 1);
        end
        check("a_glitch_press", press_cnt[0][0], 1);

        keys_v[0] = '0;
        keys_v[1] = '0;
        repeat (40) tick();
        check("a_released", lvl_v[0], 0);

        // Active-low, DEB=1: short press and release share one enable.
        check("c_idle_lvl", lvl_v[2], 0);
        for (int i = 0; i < 8 && clk_en_v[2] !== 1'b1; i++) tick();
        check("c_phase_wait", clk_en_v[2], 1);
        tick();
        clear_tallies();
        keys_v[2][3] = 1'b0;
        repeat (2) tick();
        keys_v[2][3] = 1'b1;
        repeat (12) tick();
        check("c_press_cnt", press_cnt[2][3], 1);
        check("c_rel_cnt", rel_cnt[2][3], 1);
        check("c_same_enable", both_cnt, 1);

        // Reset in the middle of debouncing key 2.
        clear_tallies();
        keys_v[0][2] = 1'b1;
        keys_v[1][2] = 1'b1;
        repeat (10) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("a_midrst_lvl", lvl_v[0][2], 0);
        check("a_midrst_press", press_cnt[0][2], 0);
        reset = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 17) check("a_redetect_before", lvl_v[0][2], 0);
            if (t == 18) check("a_redetect_after", lvl_v[0][2], 1);
        end
        check("a_redetect_press", press_cnt[0][2], 1);

        // Randomized traffic with occasional resets.
        for (int t = 0; t < 800; t++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int d = 0; d < 3; d++)
                for (int b = 0; b < NK; b++)
                    if ($urandom_range(0, (d == 2) ? 3 : 19) == 0) keys_v[d][b] = ~keys_v[d][b];
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
